// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake of the UART receive FIFO: head entry with its error flags plus valid/ready.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8
);
  // Handshake: an entry transfers on a rising clk edge where m_valid && m_ready.
  // The producer holds m_data/m_frame_err/m_parity_err stable while m_valid && !m_ready.
  logic [DATA_W-1:0] m_data;
  logic              m_frame_err;
  logic              m_parity_err;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_frame_err,
    output m_parity_err,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_frame_err,
    input  m_parity_err,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-voted bits, runtime frame format and a tagged-entry FIFO.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  uart_rx_fifo_if.master              m_if,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  // FSM state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 WAIT_IDLE
  output logic [2:0]                  state_dbg
);

  localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = $clog2(DATA_W);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = DATA_W + 2;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_DEC    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     samp_q, samp_d;
  logic              v0_q, v0_d, v1_q, v1_d;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              stop2_q, stop2_d;
  logic [1:0]        pmode_q, pmode_d;
  logic              two_stop_q, two_stop_d;
  logic              perr_q, perr_d, ferr_q, ferr_d;
  logic              push_q, push_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]     head_q, head_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];

  logic          rx_s, tick, decide, vote, start_det, parity_en;
  logic          full, pop, do_push;
  logic [EW-1:0] push_entry;

  assign rx_s       = sync2_q;
  assign tick       = (cnt_q == DIV_LAST);
  assign decide     = tick && (samp_q == S_DEC);
  assign vote       = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
  assign start_det  = (state_q == ST_IDLE) && !rx_s;
  assign parity_en  = pmode_q[0] ^ pmode_q[1];
  assign push_entry = {ferr_q, perr_q, shift_q};

  // Synchroniser, baud tick divider and per-bit sample index
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    cnt_d   = (start_det || tick) ? '0 : cnt_q + 1'b1;
    samp_d  = samp_q;
    if (start_det) begin
      samp_d = '0;
    end else if (tick) begin
      samp_d = (samp_q == S_LAST) ? '0 : samp_q + 1'b1;
    end
    v0_d = (tick && samp_q == S_V0) ? rx_s : v0_q;
    v1_d = (tick && samp_q == S_V1) ? rx_s : v1_q;
  end

  // Frame FSM: every bit decision is the vote of the third sample
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop2_d    = stop2_q;
    pmode_d    = pmode_q;
    two_stop_d = two_stop_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          pmode_d    = parity_mode;
          two_stop_d = two_stop;
          bit_cnt_d  = '0;
          stop2_d    = 1'b0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
        end
      end
      ST_START: begin
        if (decide) state_d = vote ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (decide) begin
          shift_d   = {vote, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) state_d = parity_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (decide) begin
          perr_d  = (pmode_q == 2'b01) ? (^shift_q ^ vote) : ~(^shift_q ^ vote);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          ferr_d = ferr_q | ~vote;
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            push_d  = 1'b1;
            state_d = (ferr_q | ~vote) ? ST_WAIT_IDLE : ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO control; the head register is refreshed from the post-update read pointer
  always_comb begin
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = valid_q && m_if.m_ready;
    do_push   = push_q && (!full || pop);
    overrun_d = push_q && full && !pop;
    wr_ptr_d  = wr_ptr_q + (AW + 1)'(do_push);
    rd_ptr_d  = rd_ptr_q + (AW + 1)'(pop);
    valid_d   = (wr_ptr_d != rd_ptr_d);
    head_d    = '0;
    if (valid_d) begin
      if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) head_d = push_entry;
      else head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      samp_q     <= '0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop2_q    <= 1'b0;
      pmode_q    <= 2'b00;
      two_stop_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop2_q    <= stop2_d;
      pmode_q    <= pmode_d;
      two_stop_q <= two_stop_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      push_q     <= push_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      head_q     <= head_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_if.m_data       = head_q[DATA_W-1:0];
  assign m_if.m_parity_err = head_q[DATA_W];
  assign m_if.m_frame_err  = head_q[DATA_W+1];
  assign m_if.m_valid      = valid_q;
  assign overrun           = overrun_q;
  assign fifo_count        = wr_ptr_q - rd_ptr_q;
  assign state_dbg         = state_q;

endmodule
